sprite_motion_ctrl: RTL and testbench

Upstream stage of the sprite address generator. Produces the sprite's top-left position (posx, posy) in screen pixels, once per frame. Position follows either the push-buttons (manual mode) or an autonomous bounce with edge reflection (auto mode). Updates happen only on frame_tick, which comes from the VGA timing block at the start of vertical blanking, so a frame never shows a partially moved sprite.

---
 rtl/sprite_motion_ctrl.sv | 76 +++++++
 tb/tb_sprite_motion_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame sprite origin update, manual (buttons) or autonomous bounce
//   clk, rst_n (sync, active-low), frame_tick (1-cycle frame pulse)
//   btn_left/right/up/down, auto_en : asynchronous raw levels, double-flopped inside
//   posx, posy : sprite top-left origin, clamped to the visible area
//   edge_hit   : 1-cycle pulse when an auto-mode bounce reflects on either axis
module sprite_motion_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int SPRITE_SIZE = 64,
    parameter int STEP        = 4,
    parameter int INIT_X      = 288,
    parameter int INIT_Y      = 208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       auto_en,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic       edge_hit
);
    localparam logic signed [10:0] MAX_X  = 11'(SCREEN_W - SPRITE_SIZE);
    localparam logic signed [10:0] MAX_Y  = 11'(SCREEN_H - SPRITE_SIZE);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    typedef enum logic {MANUAL, AUTO} state_t;
    state_t state, state_n;
    logic [4:0] sync1, sync2;
    logic auto_s, left_s, right_s, up_s, down_s;
    logic dir_x_neg, dir_y_neg;
    logic signed [10:0] sx, sy, nx, ny;
    logic [9:0] cx, cy;
    logic flip_x, flip_y;
    assign {auto_s, left_s, right_s, up_s, down_s} = sync2;
    always_comb begin
        state_n = frame_tick ? (auto_s ? AUTO : MANUAL) : state;
        // the update on a tick follows the rule of the state being entered
        sx = (state_n == AUTO) ? (dir_x_neg ? -STEP_S : STEP_S)
                               : (right_s ? STEP_S : 11'sd0) - (left_s ? STEP_S : 11'sd0);
        sy = (state_n == AUTO) ? (dir_y_neg ? -STEP_S : STEP_S)
                               : (down_s ? STEP_S : 11'sd0) - (up_s ? STEP_S : 11'sd0);
        nx = $signed({1'b0, posx}) + sx;
        ny = $signed({1'b0, posy}) + sy;
        cx = nx[10] ? 10'd0 : (nx > MAX_X ? MAX_X[9:0] : nx[9:0]);
        cy = ny[10] ? 10'd0 : (ny > MAX_Y ? MAX_Y[9:0] : ny[9:0]);
        flip_x = (state_n == AUTO) && (nx[10] || nx > MAX_X);
        flip_y = (state_n == AUTO) && (ny[10] || ny > MAX_Y);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            state     <= MANUAL;
            posx      <= 10'(INIT_X);
            posy      <= 10'(INIT_Y);
            dir_x_neg <= 1'b0;
            dir_y_neg <= 1'b0;
            edge_hit  <= 1'b0;
        end else begin
            sync1    <= {auto_en, btn_left, btn_right, btn_up, btn_down};
            sync2    <= sync1;
            state    <= state_n;
            edge_hit <= frame_tick && (flip_x || flip_y);
            if (frame_tick) begin
                posx <= cx;
                posy <= cy;
                // a reflection points the axis back into the screen
                if (flip_x) dir_x_neg <= !nx[10];
                if (flip_y) dir_y_neg <= !ny[10];
            end
        end
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: randomized and directed checks of sprite_motion_ctrl against a behavioural model
module tb_sprite_motion_ctrl;
    logic clk = 0, rst_n = 0, frame_tick = 0;
    logic btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0, auto_en = 0;
    logic [9:0] posx, posy;
    logic edge_hit;
    int total = 0, bad = 0;
    int px = 288, py = 208, dxm = 1, dym = 1, me = 0;
    bit mode = 0;
    logic [4:0] h_old = 0, h_new = 0;

    sprite_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .auto_en(auto_en), .posx(posx), .posy(posy), .edge_hit(edge_hit)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int mx);
        return v < 0 ? 0 : (v > mx ? mx : v);
    endfunction

    task automatic bounce(inout int p, inout int d, input int mx);
        int n = p + 4 * d;
        if (n > mx) begin p = mx; d = -1; me = 1; end
        else if (n < 0) begin p = 0; d = 1; me = 1; end
        else p = n;
    endtask

    // one clock: drive tick, update the model at the edge, return at the falling edge
    task automatic step(input logic tick);
        logic [4:0] u;
        frame_tick = tick;
        @(posedge clk);
        u = h_old;
        if (!rst_n) begin
            px = 288; py = 208; dxm = 1; dym = 1; me = 0; mode = 0; h_old = 0; h_new = 0;
        end else begin
            me = 0;
            if (tick) begin
                mode = u[4];
                if (mode) begin
                    bounce(px, dxm, 576);
                    bounce(py, dym, 416);
                end else begin
                    px = clampi(px + 4 * (int'(u[2]) - int'(u[3])), 576);
                    py = clampi(py + 4 * (int'(u[0]) - int'(u[1])), 416);
                end
            end
            h_old = h_new;
            h_new = {auto_en, btn_left, btn_right, btn_up, btn_down};
        end
        @(negedge clk);
        frame_tick = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            total++;
            if ({posx, posy, edge_hit} !== {10'd288, 10'd208, 1'b0}) begin
                bad++;
                $display("FAIL reset: got x=%0d y=%0d e=%0b want x=288 y=208 e=0", posx, posy, edge_hit);
            end
        end
        rst_n = 1;
        step(0);
        step(1);
        total++;
        if ({posx, posy, edge_hit} !== {10'd288, 10'd208, 1'b0}) begin
            bad++;
            $display("FAIL reset_idle_tick: got x=%0d y=%0d e=%0b want x=288 y=208 e=0", posx, posy, edge_hit);
        end
    endtask

    task automatic test_manual_move;
        btn_right = 1;
        step(0);
        step(0);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            total++;
            if (posx !== 10'(288 + 4 * i) || posx !== 10'(px)) begin
                bad++;
                $display("FAIL manual_right: got x=%0d want x=%0d", posx, 288 + 4 * i);
            end
            step(0);
            total++;
            if (posx !== 10'(288 + 4 * i)) begin
                bad++;
                $display("FAIL manual_hold: got x=%0d want x=%0d", posx, 288 + 4 * i);
            end
        end
        btn_left = 1;
        step(0);
        step(0);
        step(1);
        total++;
        if ({posx, posy, edge_hit} !== {10'd300, 10'd208, 1'b0}) begin
            bad++;
            $display("FAIL manual_cancel: got x=%0d y=%0d e=%0b want x=300 y=208 e=0", posx, posy, edge_hit);
        end
        btn_left = 0;
    endtask

    task automatic test_clamp;
        step(0);
        step(0);
        for (int i = 0; i < 80 && px < 576; i++) step(1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (posx !== 10'd576 || px != 576) begin
                bad++;
                $display("FAIL clamp_right: got x=%0d want x=576", posx);
            end
            step(1);
        end
        btn_up = 1;
        step(0);
        step(0);
        for (int i = 0; i < 80 && py > 0; i++) step(1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({posx, posy} !== {10'd576, 10'd0} || py != 0) begin
                bad++;
                $display("FAIL clamp_up: got x=%0d y=%0d want x=576 y=0", posx, posy);
            end
            step(1);
        end
        btn_up = 0;
        btn_right = 0;
    endtask

    task automatic test_bounce;
        btn_left = 1;
        btn_down = 1;
        step(0);
        step(0);
        step(1);
        btn_left = 0;
        step(0);
        step(0);
        for (int i = 0; i < 40 && py < 100; i++) step(1);
        btn_down = 0;
        auto_en = 1;
        step(0);
        step(0);
        total++;
        if ({posx, posy} !== {10'd572, 10'd100}) begin
            bad++;
            $display("FAIL bounce_setup: got x=%0d y=%0d want x=572 y=100", posx, posy);
        end
        step(1);
        total++;
        if ({posx, posy, edge_hit} !== {10'd576, 10'd104, 1'b0}) begin
            bad++;
            $display("FAIL bounce_reach: got x=%0d y=%0d e=%0b want x=576 y=104 e=0", posx, posy, edge_hit);
        end
        step(1);
        total++;
        if ({posx, posy, edge_hit} !== {10'd576, 10'd108, 1'b1}) begin
            bad++;
            $display("FAIL bounce_flip: got x=%0d y=%0d e=%0b want x=576 y=108 e=1", posx, posy, edge_hit);
        end
        step(0);
        total++;
        if (edge_hit !== 1'b0) begin
            bad++;
            $display("FAIL bounce_pulse: got e=%0b want e=0", edge_hit);
        end
        step(1);
        total++;
        if ({posx, posy, edge_hit} !== {10'd572, 10'd112, 1'b0}) begin
            bad++;
            $display("FAIL bounce_back: got x=%0d y=%0d e=%0b want x=572 y=112 e=0", posx, posy, edge_hit);
        end
    endtask

    task automatic test_sampling;
        int y0;
        auto_en = 0;
        step(0);
        step(0);
        step(1);
        y0 = py;
        btn_down = 1;
        for (int i = 0; i < 10; i++) step(0);
        btn_down = 0;
        for (int i = 0; i < 3; i++) step(0);
        step(1);
        total++;
        if (posy !== 10'(y0) || py != y0) begin
            bad++;
            $display("FAIL sample_between: got y=%0d want y=%0d", posy, y0);
        end
        btn_down = 1;
        step(0);
        step(1);
        total++;
        if (posy !== 10'(y0)) begin
            bad++;
            $display("FAIL sync_delay: got y=%0d want y=%0d", posy, y0);
        end
        step(0);
        step(1);
        total++;
        if (posy !== 10'(y0 + 4) || py != y0 + 4) begin
            bad++;
            $display("FAIL sync_seen: got y=%0d want y=%0d", posy, y0 + 4);
        end
        btn_down = 0;
    endtask

    task automatic test_back_to_back;
        auto_en = 1;
        step(0);
        step(0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            total++;
            if ({posx, posy, edge_hit} !== {10'(px), 10'(py), 1'(me)}) begin
                bad++;
                $display("FAIL back_to_back: got x=%0d y=%0d e=%0b want x=%0d y=%0d e=%0d", posx, posy, edge_hit, px, py, me);
            end
        end
    endtask

    task automatic test_reset_mid_bounce;
        auto_en = 0;
        rst_n = 0;
        step(1);
        total++;
        if ({posx, posy, edge_hit} !== {10'd288, 10'd208, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: got x=%0d y=%0d e=%0b want x=288 y=208 e=0", posx, posy, edge_hit);
        end
        rst_n = 1;
        step(0);
        step(0);
        step(1);
        total++;
        if ({posx, posy, edge_hit} !== {10'd288, 10'd208, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_tick: got x=%0d y=%0d e=%0b want x=288 y=208 e=0", posx, posy, edge_hit);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            {btn_left, btn_right, btn_up, btn_down} = 4'($urandom);
            if ($urandom_range(0, 40) == 0) auto_en = ~auto_en;
            rst_n = ($urandom_range(0, 400) != 0);
            step($urandom_range(0, 2) == 0);
            total++;
            if ({posx, posy, edge_hit} !== {10'(px), 10'(py), 1'(me)} || posx > 10'd576 || posy > 10'd416) begin
                bad++;
                $display("FAIL random[%0d]: got x=%0d y=%0d e=%0b want x=%0d y=%0d e=%0d", i, posx, posy, edge_hit, px, py, me);
            end
        end
        rst_n = 1;
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_manual_move;
        test_clamp;
        test_bounce;
        test_sampling;
        test_back_to_back;
        test_reset_mid_bounce;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
